data_mem_responder: RTL and testbench

//  Responder end of the pipeline's data-memory interface. Accepts one

---
 rtl/data_mem_if.sv | 28 ++
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Data-memory request/response bus between a pipeline (master) and a memory
// responder (slave).
//   req_valid/req_ready  : request handshake, master -> slave
//   req_write            : 1 = store, 0 = load
//   req_addr/req_wdata   : byte address and store data
//   resp_valid/resp_ready: response handshake, slave -> master
//   resp_rdata/resp_err  : load data and error flag
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder. Accepts one load/store at a time on the
// request channel and returns its completion LATENCY cycles after acceptance
// on the response channel, holding it until the requester consumes it.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-low reset; clears FSM, outputs and the store
//   bus   : data_mem_if slave modport (request and response channels)
// Parameters:
//   DEPTH   : words in the backing store (power of 2)
//   BASE    : byte address of word 0
//   LATENCY : cycles from accept to resp_valid (>= 1)
module data_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h1000_0000,
  parameter int unsigned LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(LATENCY) + 1;
  localparam logic [31:0] LIMIT = BASE + 32'(4 * DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            write_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            err_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic [31:0]     resp_rdata_q;
  logic            resp_err_q;
  logic [31:0]     mem [DEPTH];

  // Decode of the incoming request.
  logic            req_err;
  logic [AW-1:0]   req_idx;
  logic            accept;

  // Request being committed on entry to StResp: taken straight from the bus
  // when LATENCY==1 (accept and commit share an edge), else from the latches.
  logic            c_write;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_wdata;
  logic            c_err;
  logic            enter_resp;

  always_comb begin
    req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE) ||
              (bus.req_addr >= LIMIT);
    req_idx = AW'((bus.req_addr - BASE) >> 2);
    // req_ready_q is only ever high in StIdle.
    accept  = bus.req_valid && req_ready_q;
  end

  always_comb begin
    c_write = write_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_err   = err_q;
    if (state_q == StIdle) begin
      c_write = bus.req_write;
      c_idx   = req_idx;
      c_wdata = bus.req_wdata;
      c_err   = req_err;
    end
    // cnt_q holds the cycles still to elapse before resp_valid; leave StBusy
    // on the cycle the last of them runs out.
    enter_resp = ((state_q == StIdle) && accept && (LATENCY == 1)) ||
                 ((state_q == StBusy) && (cnt_q == CW'(1)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            write_q     <= bus.req_write;
            idx_q       <= req_idx;
            wdata_q     <= bus.req_wdata;
            err_q       <= req_err;
            req_ready_q <= 1'b0;
            cnt_q       <= CW'(LATENCY - 1);
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - CW'(1);
        end
        StResp: begin
          if (bus.resp_ready) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // Commit: the store lands before the response is visible, so a later
      // load of the same word always sees it.
      if (enter_resp) begin
        state_q      <= StResp;
        resp_valid_q <= 1'b1;
        resp_err_q   <= c_err;
        resp_rdata_q <= (!c_write && !c_err) ? mem[c_idx] : 32'h0;
        if (c_write && !c_err) begin
          mem[c_idx] <= c_wdata;
        end
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=3 instance driven from a
// table of load/store vectors plus hand sequences (stall, reset mid-flight),
// and a LATENCY=1 instance for back-to-back timing.
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned LAT  = 3;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  data_mem_if bus3();
  data_mem_if bus1();

  data_mem_responder #(
    .DEPTH  (1024),
    .BASE   (BASE),
    .LATENCY(LAT)
  ) dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3)
  );

  data_mem_responder #(
    .DEPTH  (16),
    .BASE   (BASE),
    .LATENCY(1)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called and returns at a negedge. Issues one request on bus3 and checks
  // latency, response contents and release of the response.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int n;
    n = 0;
    bus3.req_valid = 1'b1;
    bus3.req_write = wr;
    bus3.req_addr  = addr;
    bus3.req_wdata = wdata;
    while (!bus3.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus3.req_ready) begin
      chk({tag, " accept timeout"}, 32'(n), 32'd0);
      bus3.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus3.req_valid = 1'b0;
    n = 1;
    while (!bus3.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(LAT));
    chk({tag, " rdata"}, bus3.resp_rdata, exp_rdata);
    chk({tag, " err"}, 32'(bus3.resp_err), 32'(exp_err));
    bus3.resp_ready = 1'b1;
    @(negedge clk);
    bus3.resp_ready = 1'b0;
    chk({tag, " resp released"}, 32'(bus3.resp_valid), 32'd0);
    chk({tag, " ready again"}, 32'(bus3.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b0, BASE + 32'h0,     32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b1, BASE + 32'h8,     32'hDEADBEEF,  32'h0,         1'b0};
    vecs[2]  = '{1'b0, BASE + 32'h8,     32'h0,         32'hDEADBEEF,  1'b0};
    vecs[3]  = '{1'b0, BASE + 32'h2,     32'h0,         32'h0,         1'b1};
    vecs[4]  = '{1'b0, BASE + 32'h1000,  32'h0,         32'h0,         1'b1};
    vecs[5]  = '{1'b1, BASE + 32'h1000,  32'hCAFEF00D,  32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h0FFF_FFFC,    32'hA5A5A5A5,  32'h0,         1'b1};
    vecs[7]  = '{1'b1, BASE + 32'h6,     32'h5555AAAA,  32'h0,         1'b1};
    vecs[8]  = '{1'b0, BASE + 32'h0,     32'h0,         32'h0,         1'b0};
    vecs[9]  = '{1'b1, BASE + 32'hFFC,   32'h11223344,  32'h0,         1'b0};
    vecs[10] = '{1'b0, BASE + 32'hFFC,   32'h0,         32'h11223344,  1'b0};
    vecs[11] = '{1'b0, BASE + 32'h8,     32'h0,         32'hDEADBEEF,  1'b0};
    vecs[12] = '{1'b0, BASE + 32'h4,     32'h0,         32'h0,         1'b0};
    vecs[13] = '{1'b1, BASE + 32'h8,     32'h00000001,  32'h0,         1'b0};
    vecs[14] = '{1'b0, BASE + 32'h8,     32'h0,         32'h00000001,  1'b0};

    reset = 1'b0;
    bus3.req_valid  = 1'b0;
    bus3.req_write  = 1'b0;
    bus3.req_addr   = '0;
    bus3.req_wdata  = '0;
    bus3.resp_ready = 1'b0;
    bus1.req_valid  = 1'b0;
    bus1.req_write  = 1'b0;
    bus1.req_addr   = '0;
    bus1.req_wdata  = '0;
    bus1.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("reset req_ready", 32'(bus3.req_ready), 32'd1);
    chk("reset resp_valid", 32'(bus3.resp_valid), 32'd0);
    chk("reset resp_rdata", bus3.resp_rdata, 32'h0);
    chk("reset resp_err", 32'(bus3.resp_err), 32'd0);

    for (int i = 0; i < 15; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
          $sformatf("vec%0d", i));
    end

    // Stall in the response state; a competing store must not be accepted.
    bus3.req_valid = 1'b1;
    bus3.req_write = 1'b0;
    bus3.req_addr  = BASE + 32'hFFC;
    @(negedge clk);
    bus3.req_valid = 1'b0;
    n = 1;
    while (!bus3.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall latency", 32'(n), 32'(LAT));
    bus3.req_valid = 1'b1;
    bus3.req_write = 1'b1;
    bus3.req_addr  = BASE + 32'hC;
    bus3.req_wdata = 32'h99;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d resp_valid", c), 32'(bus3.resp_valid), 32'd1);
      chk($sformatf("stall%0d rdata", c), bus3.resp_rdata, 32'h11223344);
      chk($sformatf("stall%0d req_ready", c), 32'(bus3.req_ready), 32'd0);
    end
    bus3.req_valid  = 1'b0;
    bus3.resp_ready = 1'b1;
    @(negedge clk);
    bus3.resp_ready = 1'b0;
    txn(1'b0, BASE + 32'hC, 32'h0, 32'h0, 1'b0, "post-stall load");

    // Reset while a store sits in BUSY.
    bus3.req_valid = 1'b1;
    bus3.req_write = 1'b1;
    bus3.req_addr  = BASE + 32'h4;
    bus3.req_wdata = 32'h1234;
    @(negedge clk);
    bus3.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midreset resp_valid", 32'(bus3.resp_valid), 32'd0);
    chk("midreset rdata", bus3.resp_rdata, 32'h0);
    chk("midreset err", 32'(bus3.resp_err), 32'd0);
    chk("midreset req_ready", 32'(bus3.req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("idle after reset", 32'(bus3.resp_valid), 32'd0);
    txn(1'b0, BASE + 32'h4, 32'h0, 32'h0, 1'b0, "load after reset");
    txn(1'b0, BASE + 32'h8, 32'h0, 32'h0, 1'b0, "store cleared by reset");

    // LATENCY=1 instance, back-to-back with resp_ready held high.
    bus1.req_valid  = 1'b1;
    bus1.req_write  = 1'b1;
    bus1.req_addr   = BASE;
    bus1.req_wdata  = 32'h77;
    bus1.resp_ready = 1'b1;
    chk("l1 ready", 32'(bus1.req_ready), 32'd1);
    @(negedge clk);
    chk("l1 store resp_valid", 32'(bus1.resp_valid), 32'd1);
    chk("l1 store req_ready", 32'(bus1.req_ready), 32'd0);
    chk("l1 store err", 32'(bus1.resp_err), 32'd0);
    bus1.req_write = 1'b0;
    @(negedge clk);
    chk("l1 gap resp_valid", 32'(bus1.resp_valid), 32'd0);
    chk("l1 gap req_ready", 32'(bus1.req_ready), 32'd1);
    @(negedge clk);
    chk("l1 load resp_valid", 32'(bus1.resp_valid), 32'd1);
    chk("l1 load rdata", bus1.resp_rdata, 32'h77);
    bus1.req_valid = 1'b0;
    @(negedge clk);
    chk("l1 done resp_valid", 32'(bus1.resp_valid), 32'd0);
    bus1.resp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
